// File: rtl/mean_level_detector.sv
// Debounced hysteresis level detector for the moving-average mean: rise/fall pulses,
// per-episode peak hold, saturating rise-event counter and a registered threshold-config error.
module mean_level_detector #(
    parameter int unsigned W    = 4,
    parameter int unsigned HOLD = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] mean_in,
    input  logic [W-1:0] th_hi,
    input  logic [W-1:0] th_lo,
    input  logic         clr,
    output logic         level,
    output logic         rise,
    output logic         fall,
    output logic [W-1:0] peak,
    output logic [7:0]   evt_cnt,
    output logic         cfg_err
);

    localparam int unsigned CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {StLow, StPendHigh, StHigh, StPendLow} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]   peak_q, peak_d, peak_run_q, peak_run_d;
    logic           rise_q, rise_d, fall_q, fall_d;
    logic [7:0]     evt_q, evt_d;
    logic           cfg_err_q, cfg_err_d;
    logic           hi_ok, lo_ok, hold_hit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        peak_run_d = peak_run_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        hi_ok      = (mean_in >= th_hi);
        lo_ok      = (mean_in <= th_lo);
        cnt_inc    = cnt_q + CW'(1);
        hold_hit   = (cnt_inc == CW'(HOLD));

        // A registered config error freezes all debounce state.
        if (en && !cfg_err_q) begin
            unique case (state_q)
                StLow: begin
                    if (hi_ok) begin
                        if (HOLD == 1) begin
                            state_d = StHigh;
                            rise_d  = 1'b1;
                            peak_d  = mean_in;
                        end else begin
                            state_d    = StPendHigh;
                            cnt_d      = CW'(1);
                            peak_run_d = mean_in;
                        end
                    end
                end
                StPendHigh: begin
                    if (hi_ok) begin
                        if (hold_hit) begin
                            state_d = StHigh;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                            peak_d  = (mean_in > peak_run_q) ? mean_in : peak_run_q;
                        end else begin
                            cnt_d      = cnt_inc;
                            peak_run_d = (mean_in > peak_run_q) ? mean_in : peak_run_q;
                        end
                    end else begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end
                end
                StHigh: begin
                    peak_d = (mean_in > peak_q) ? mean_in : peak_q;
                    if (lo_ok) begin
                        if (HOLD == 1) begin
                            state_d = StLow;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = StPendLow;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                StPendLow: begin
                    peak_d = (mean_in > peak_q) ? mean_in : peak_q;
                    if (lo_ok) begin
                        if (hold_hit) begin
                            state_d = StLow;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end
                end
            endcase
        end

        evt_d = evt_q;
        if (rise_d && (evt_q != 8'd255)) begin
            evt_d = evt_q + 8'd1;
        end
        if (clr) begin
            evt_d = 8'd0;
        end

        cfg_err_d = (th_lo >= th_hi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLow;
            cnt_q      <= '0;
            peak_q     <= '0;
            peak_run_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            evt_q      <= 8'd0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            peak_run_q <= peak_run_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            evt_q      <= evt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign level   = (state_q == StHigh) || (state_q == StPendLow);
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign peak    = peak_q;
    assign evt_cnt = evt_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mean_level_detector.sv
// Self-checking bench: directed mean sequences, a level/run-count model checked every
// cycle, and literal expectations for the key points of each scenario.
module tb_mean_level_detector;

    localparam int W    = 4;
    localparam int HOLD = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] mean_in = '0;
    logic [W-1:0] th_hi = 4'd12;
    logic [W-1:0] th_lo = 4'd4;
    logic         clr = 1'b0;
    logic         level, rise, fall, cfg_err;
    logic [W-1:0] peak;
    logic [7:0]   evt_cnt;

    int total = 0;
    int bad   = 0;

    mean_level_detector #(.W(W), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mean_in (mean_in),
        .th_hi   (th_hi),
        .th_lo   (th_lo),
        .clr     (clr),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .peak    (peak),
        .evt_cnt (evt_cnt),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a level flag plus the length of the current qualifying run toward the other level.
    int m_level, m_run, m_runmax, m_peak, m_evt, m_cfg, m_rise, m_fall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_level = 0; m_run = 0; m_runmax = 0; m_peak = 0;
            m_evt = 0; m_cfg = 0; m_rise = 0; m_fall = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (en && m_cfg == 0) begin
                if (m_level == 0) begin
                    if (int'(mean_in) >= int'(th_hi)) begin
                        m_run++;
                        m_runmax = (m_run == 1) ? int'(mean_in)
                                 : ((int'(mean_in) > m_runmax) ? int'(mean_in) : m_runmax);
                        if (m_run == HOLD) begin
                            m_level = 1; m_rise = 1; m_peak = m_runmax; m_run = 0;
                            m_evt = (m_evt < 255) ? m_evt + 1 : 255;
                        end
                    end else m_run = 0;
                end else begin
                    if (int'(mean_in) > m_peak) m_peak = int'(mean_in);
                    if (int'(mean_in) <= int'(th_lo)) begin
                        m_run++;
                        if (m_run == HOLD) begin
                            m_level = 0; m_fall = 1; m_run = 0;
                        end
                    end else m_run = 0;
                end
            end
            if (clr) m_evt = 0;
            m_cfg = (th_lo >= th_hi) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("level", int'(level), m_level);
            chk("rise", int'(rise), m_rise);
            chk("fall", int'(fall), m_fall);
            chk("peak", int'(peak), m_peak);
            chk("evt_cnt", int'(evt_cnt), m_evt);
            chk("cfg_err", int'(cfg_err), m_cfg);
            if (rise && fall) chk("rise_and_fall", 1, 0);
        end
    end

    task automatic step(input logic e, input logic [W-1:0] m);
        en = e;
        mean_in = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises;
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_peak", int'(peak), 0);
        chk("reset_evt", int'(evt_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Debounce: 12,13 broken by 11, then 12,14,12 commits.
        step(1, 12); step(1, 13); step(1, 11);
        chk("no_rise_broken_run", int'(level), 0);
        step(1, 12); step(1, 14);
        chk("no_rise_before_hold", int'(rise), 0);
        step(1, 12);
        chk("t2_rise", int'(rise), 1);
        chk("t2_level", int'(level), 1);
        chk("t2_peak", int'(peak), 14);
        chk("t2_evt", int'(evt_cnt), 1);
        step(0, 0);
        chk("t2_rise_one_cycle", int'(rise), 0);

        // Hysteresis.
        step(1, 11); step(1, 8); step(1, 5); step(1, 15);
        chk("t3_peak15", int'(peak), 15);
        chk("t3_still_high", int'(level), 1);
        step(1, 4); step(1, 4);
        chk("t3_no_fall_yet", int'(fall), 0);
        step(1, 3);
        chk("t3_fall", int'(fall), 1);
        chk("t3_level", int'(level), 0);
        chk("t3_peak_held", int'(peak), 15);

        // Reset while HIGH.
        step(1, 13); step(1, 13); step(1, 13);
        chk("t1_in_high", int'(level), 1);
        rst = 1'b1;
        #1;
        chk("t1_level", int'(level), 0);
        chk("t1_rise", int'(rise), 0);
        chk("t1_peak", int'(peak), 0);
        chk("t1_evt", int'(evt_cnt), 0);
        chk("t1_cfg", int'(cfg_err), 0);
        #3 rst = 1'b0;
        step(0, 0);
        chk("t1_low_after", int'(level), 0);

        // Enable gating.
        step(1, 12); step(0, 0); step(1, 12);
        chk("t4_no_rise", int'(rise), 0);
        step(1, 12);
        chk("t4_rise", int'(rise), 1);
        step(1, 0); step(1, 0); step(1, 0);
        chk("t4_back_low", int'(level), 0);

        // Config error freeze in PEND_HIGH with one sample counted.
        step(1, 12);
        th_lo = 4'd8; th_hi = 4'd8;
        step(0, 0);
        chk("t5_cfg_set", int'(cfg_err), 1);
        step(1, 12); step(1, 12); step(1, 12);
        chk("t5_frozen_level", int'(level), 0);
        chk("t5_frozen_rise", int'(rise), 0);
        th_lo = 4'd4; th_hi = 4'd12;
        step(0, 0);
        chk("t5_cfg_clear", int'(cfg_err), 0);
        step(1, 12);
        chk("t5_no_rise_yet", int'(rise), 0);
        step(1, 12);
        chk("t5_rise", int'(rise), 1);
        step(1, 0); step(1, 0); step(1, 0);

        // Saturation and clr.
        rises = int'(evt_cnt);
        for (int i = rises; i < 256; i++) begin
            step(1, 15); step(1, 15); step(1, 15);
            step(1, 0); step(1, 0); step(1, 0);
        end
        chk("t6_sat", int'(evt_cnt), 255);
        step(1, 15); step(1, 15); step(1, 15);
        chk("t6_sat_hold", int'(evt_cnt), 255);
        step(1, 0); step(1, 0); step(1, 0);
        step(1, 15); step(1, 15);
        clr = 1'b1;
        step(1, 15);
        clr = 1'b0;
        chk("t6_clr_rise", int'(rise), 1);
        chk("t6_clr_wins", int'(evt_cnt), 0);
        step(0, 0); step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mean_level_detector.md
# mean_level_detector

Downstream consumer of the 4-sample moving-average stage. Takes the registered mean value and classifies it into a debounced HIGH/LOW level using programmable hysteresis thresholds. It emits single-cycle rise and fall pulses, holds the peak mean seen during each HIGH episode, and keeps a saturating count of HIGH episodes for status readout.

## Interface
- W, default 4: sample and threshold width; matches the mean stage output.
- HOLD, default 3: number of consecutive qualifying enabled samples required to change level. Legal range 1..15.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  sample enable; `mean_in` is evaluated only on edges where en=1.
- mean_in  in  W  moving-average value from the upstream mean stage.
- th_hi  in  W  rise threshold; a sample qualifies when mean_in >= th_hi.
- th_lo  in  W  fall threshold; a sample qualifies when mean_in <= th_lo.
- clr  in  1  synchronous clear of `evt_cnt`.
- level  out  1  debounced level: 1 in HIGH and PEND_LOW.
- rise  out  1  one-cycle pulse on LOW→HIGH commit.
- fall  out  1  one-cycle pulse on HIGH→LOW commit.
- peak  out  W  maximum mean_in of the current or last HIGH episode.
- evt_cnt  out  8  number of rise events, saturating at 255.
- cfg_err  out  1  registered flag, set when th_lo >= th_hi.

## Operation
- **Reset:** state=LOW, cnt=0. All outputs are 0.
- **FSM states:** LOW, PEND_HIGH, HIGH, PEND_LOW. The debounce counter `cnt` is ceil(log2(HOLD+1)) bits wide.
- **LOW:** an enabled sample with mean_in >= th_hi goes to PEND_HIGH with cnt=1. If HOLD=1, it goes straight to HIGH with rise.
- **PEND_HIGH:**
  - Qualifying sample: cnt+1. When cnt+1 == HOLD, go to HIGH, pulse rise, cnt=0.
  - Enabled non-qualifying sample: back to LOW, cnt=0. No pulse.
- **HIGH:** an enabled sample with mean_in <= th_lo goes to PEND_LOW with cnt=1. If HOLD=1, it goes straight to LOW with fall.
- **PEND_LOW:**
  - Qualifying sample: cnt+1. When cnt+1 == HOLD, go to LOW, pulse fall, cnt=0.
  - Enabled sample with mean_in > th_lo: back to HIGH, cnt=0. No pulse.
- **en=0:** state, cnt and peak hold. Disabled cycles do not break a consecutive run.
- **Samples between th_lo and th_hi:** in HIGH, a sample with th_lo < mean_in < th_hi keeps HIGH. In LOW, the same range keeps LOW.
- **peak:**
  - On the rise commit, peak <= max(peak_run, mean_in), where peak_run is the maximum over the qualifying PEND_HIGH run.
  - While in HIGH or PEND_LOW with en=1, peak <= max(peak, mean_in).
  - peak is held unchanged in LOW until the next rise.
- **cfg_err:** registered every cycle from (th_lo >= th_hi). While cfg_err=1:
  - The FSM, cnt and peak are frozen.
  - No rise or fall pulses are generated.
  - When cfg_err clears, operation resumes from the frozen state.
- **evt_cnt:**
  - Increments on each rise commit and saturates at 255.
  - clr=1 sets it to 0. clr wins over a simultaneous rise.
- **Arithmetic:** all comparisons are unsigned, W bits.

## Timing
- **Sample timing:** a sample is taken at edge k when en=1 at edge k. The mean stage output registered at edge k-1 is the value sampled at edge k.
- **Commit timing:** level, rise, fall and peak update after the edge that commits the HOLD-th qualifying sample.
  - Latency from first qualifying sample to level change: HOLD edges.
  - End-to-end from raw input to level change: HOLD+1 edges after the mean stage.
- **Pulse width:** rise and fall are high for exactly one cycle. They are never high together.
- **cfg_err latency:** one edge after the threshold change. The freeze applies from the edge after cfg_err is set.
- **Reset mid-operation:** asynchronous clear to reset values, including pulses in flight and cnt. evt_cnt and peak are cleared too.

## Test plan
1. **Reset:** assert rst mid-run while in HIGH → level, rise, fall, peak, evt_cnt and cfg_err are 0 immediately. After release, state is LOW.
2. **Debounce:** HOLD=3, th_hi=12, th_lo=4, en=1, feed 12,13,11,12,14,12.
   - No rise on 12,13 (run broken by 11).
   - rise=1 for one cycle after the 6th sample; level=1, peak=14, evt_cnt=1.
3. **Hysteresis:** in HIGH, feed 11,8,5,15,4,4,3.
   - No fall on 11/8/5/15; peak=15 after the 15.
   - fall=1 after the 3 (third consecutive <=4); level=0, peak stays 15.
4. **Enable gating:** HOLD=3, feed 12 (en=1), 0 (en=0), 12 (en=1), 12 (en=1) → rise after the 4th edge. The disabled sample is ignored.
5. **Config error:** in PEND_HIGH with cnt=1, set th_lo=8, th_hi=8 → cfg_err=1 next cycle.
   - Subsequent qualifying samples give no rise.
   - Restore th_lo=4; then 2 more qualifying samples → rise.
6. **Saturation and clr:** generate 256 rise events → evt_cnt=255 and holds. clr concurrent with a rise → evt_cnt=0 next cycle.
